safety_island_boot_ctrl: RTL and testbench
==========================================

# safety_island_boot_ctrl

Boot sequencer for the safety island. It sits between the SoC control registers and the CV32 core. It samples the boot mode after reset and waits for a boot entry point, either from a JTAG debugger or from an external preloader. It then holds the core in reset for a programmable settle delay and finally raises fetch enable with the latched boot address. It consumes the `bootmode_e` encoding and the BootROM address map constants from `safety_island_pkg`.

## Interface
Parameters:
- `BaseAddr`, 32'h6000_0000, island base address.
- `BootRomOffset`, `safety_island_pkg::BootROMAddrOffset`, BootROM offset from `BaseAddr`; also the fallback entry.
- `ResetDelayCycles`, 16, core-reset hold after entry is known; legal range 1..255.
- `TimeoutCycles`, 32'd1_048_576, preload timeout; legal range ≥2; used only with `SAFETY_ISLAND_BOOT_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `bootmode_i`  in  2  `bootmode_e`; static during boot.
- `fetch_en_reg_i`  in  1  SoC-ctrl fetch-enable bit, written by JTAG.
- `entry_addr_i`  in  32  entry address from SoC-ctrl register.
- `entry_valid_i`  in  1  preloader done pulse (Preloaded mode).
- `core_rst_o`  out  1  active-high core reset.
- `fetch_en_o`  out  1  core fetch enable.
- `boot_addr_o`  out  32  latched boot address.
- `boot_done_o`  out  1  core running.
- `boot_err_o`  out  1  sticky error.
- `timeout_o`  out  1  sticky; fallback boot was taken.
- `state_o`  out  3  FSM state encoding, for the status register.

## Operation
- States, encoding 0..5: `Sample`, `WaitJtag`, `WaitPreload`, `Delay`, `Run`, `Error`.
- Reset state is `Sample`. Output reset values:
  - `core_rst_o`=1.
  - `fetch_en_o`, `boot_done_o`, `boot_err_o`, `timeout_o`=0.
  - `boot_addr_o`=`BaseAddr+BootRomOffset`.
- `Sample` decodes `bootmode_i` and always leaves after one cycle:
  - `Jtag` → `WaitJtag`.
  - `Preloaded` → `WaitPreload`.
  - 2'b10 or 2'b11 → `Error`.
- `WaitJtag` waits for `fetch_en_reg_i`=1, then latches `entry_addr_i` → `Delay`. `entry_valid_i` is ignored in this state.
- `WaitPreload` waits for `entry_valid_i`=1, then latches `entry_addr_i` → `Delay`. `fetch_en_reg_i` is ignored in this state.
- Alignment check at the latch point:
  - If `entry_addr_i[1:0]`≠0, go to `Error` instead of `Delay`.
  - `boot_addr_o` is not updated in that case.
- `Delay` loads a down-counter with `ResetDelayCycles-1` on entry and keeps `core_rst_o`=1. When the counter reaches 0, go to `Run`.
- `Run`:
  - `core_rst_o`=0, `fetch_en_o`=1, `boot_done_o`=1.
  - Terminal until reset.
  - Later changes on `fetch_en_reg_i`, `entry_valid_i` or `entry_addr_i` have no effect.
- `Error`:
  - `boot_err_o`=1, `core_rst_o`=1, `fetch_en_o`=0.
  - Terminal until reset.
- `rst_i` asserted in any state, including mid-`Delay`, returns to `Sample` with reset output values on the next edge. `core_rst_o` rises in that same edge.
- `boot_addr_o` is registered and changes only at a successful latch. It is stable from `Delay` onward.

## Timing
- All outputs are registered and decoded from state/flags. There is no combinational path from inputs to outputs.
- Let cycle 0 be the first cycle with `rst_i`=0. `bootmode_i` is sampled in cycle 0, and the FSM is in a wait state in cycle 1.
- Entry accepted in cycle N:
  - `Delay` occupies cycles N+1 .. N+`ResetDelayCycles`.
  - In cycle N+`ResetDelayCycles`+1, `core_rst_o` falls and `fetch_en_o`/`boot_done_o` rise together.
- If the trigger is already high in cycle 1, it is accepted in cycle 1. Minimum boot latency is `ResetDelayCycles`+2 cycles after reset release.
- `entry_valid_i` is level-qualified and only needs to be high for one cycle. It has no effect outside `WaitPreload`.

## Configuration
- `SAFETY_ISLAND_BOOT_TIMEOUT_EN` defined:
  - `WaitPreload` runs a counter from 0.
  - If `entry_valid_i` has not arrived when the counter reaches `TimeoutCycles-1`, the next edge goes to `Delay` with `boot_addr_o`=`BaseAddr+BootRomOffset` and sets `timeout_o`=1.
  - If `entry_valid_i` arrives in the expiry cycle, the valid entry wins.
- Undefined:
  - No counter is present.
  - `WaitPreload` waits indefinitely.
  - `timeout_o` is tied to 0.

## Structure
- `safety_island_pkg` gets:
  - `boot_state_e` (3-bit enum above).
  - `BootDelayWidth`=8.
  - `BootTimeoutWidth`=32.
- The existing `bootmode_e` and `BootROMAddrOffset` are reused from the package.
- Sub-module `safety_island_boot_cnt`: a loadable down-counter with a zero flag. It is instantiated once for `Delay` and once for the timeout (timeout instance only under the macro).

## Test plan
- Jtag mode, `ResetDelayCycles`=4, `fetch_en_reg_i`=1 in cycle 10 with `entry_addr_i`=32'h6000_1080 → `Delay` in cycles 11–14; cycle 15: `core_rst_o`=0, `fetch_en_o`=1, `boot_addr_o`=32'h6000_1080.
- Preloaded mode, `entry_valid_i` pulse in cycle 5 with 32'h6001_0000, and `fetch_en_reg_i` toggled earlier → JTAG toggle ignored; boot at cycle 5+`ResetDelayCycles`+1 with 32'h6001_0000.
- `bootmode_i`=2'b11 → cycle 1 `state_o`=5, `boot_err_o`=1, `core_rst_o` stays 1; a later `entry_valid_i` has no effect.
- Misaligned entry 32'h6000_1082 in Preloaded mode → `Error`; `boot_addr_o` keeps 32'h6000_1000.
- `rst_i` pulsed in the 2nd `Delay` cycle → `Sample` next edge, `core_rst_o`=1, `boot_addr_o` reset; a fresh boot then completes normally.
- With the macro and `TimeoutCycles`=100, no `entry_valid_i` → fallback entry 32'h6000_1000, `timeout_o`=1; `entry_valid_i` exactly in the expiry cycle → supplied address used, `timeout_o`=0.

Source files
------------

// File: rtl/safety_island_pkg.sv
// -----------------------------------------------------------------------------
// safety_island_pkg
// Shared types and constants for the safety island: boot mode encoding,
// BootROM address map and the boot sequencer state/counter widths.
// -----------------------------------------------------------------------------
package safety_island_pkg;

   // Boot mode driven by the SoC control registers; 2'b10/2'b11 are illegal.
   typedef enum logic [1:0] {
      Jtag      = 2'b00,
      Preloaded = 2'b01
   } bootmode_e;

   // BootROM offset from the island base address.
   localparam logic [31:0] BootROMAddrOffset = 32'h0000_1000;

   // Boot sequencer counter widths.
   localparam int unsigned BootDelayWidth   = 8;
   localparam int unsigned BootTimeoutWidth = 32;

   // Boot sequencer states; the encoding is exported through the status register.
   typedef enum logic [2:0] {
      Sample      = 3'd0,
      WaitJtag    = 3'd1,
      WaitPreload = 3'd2,
      Delay       = 3'd3,
      Run         = 3'd4,
      Error       = 3'd5
   } boot_state_e;

endpackage : safety_island_pkg

// File: rtl/safety_island_boot_cnt.sv
// -----------------------------------------------------------------------------
// safety_island_boot_cnt
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrement saturates at zero.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (counter clears to 0)
//   load_i      load load_val_i on the next edge
//   load_val_i  value to load
//   dec_i       decrement on the next edge (ignored at zero)
//   cnt_o       current count (registered)
//   zero_c      count is zero (combinational decode of the count register)
// -----------------------------------------------------------------------------
module safety_island_boot_cnt #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic [Width-1:0] cnt_o,
   output logic             zero_c
);

   logic [Width-1:0] cnt_q, cnt_d;

   // Next count.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_c = (cnt_q == '0);

endmodule : safety_island_boot_cnt

// File: rtl/safety_island_boot_ctrl.sv
// -----------------------------------------------------------------------------
// safety_island_boot_ctrl
// Boot sequencer for the safety island. Samples the boot mode, waits for an
// entry point (JTAG fetch-enable or preloader valid), holds the core in reset
// for ResetDelayCycles and then releases it with fetch enable and the latched
// boot address.
//
// Optional feature: define SAFETY_ISLAND_BOOT_TIMEOUT_EN to add a preload
// timeout that falls back to the BootROM entry and sets timeout_o.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   bootmode_i      boot mode (bootmode_e), static during boot
//   fetch_en_reg_i  SoC-ctrl fetch-enable bit (JTAG trigger)
//   entry_addr_i    entry address from SoC-ctrl
//   entry_valid_i   preloader done pulse
//   core_rst_o      active-high core reset
//   fetch_en_o      core fetch enable
//   boot_addr_o     latched boot address
//   boot_done_o     core running
//   boot_err_o      sticky boot error
//   timeout_o       sticky, fallback boot taken
//   state_o         FSM state encoding
// -----------------------------------------------------------------------------
module safety_island_boot_ctrl
   import safety_island_pkg::*;
#(
   parameter logic [31:0] BaseAddr         = 32'h6000_0000,
   parameter logic [31:0] BootRomOffset    = safety_island_pkg::BootROMAddrOffset,
   parameter int unsigned ResetDelayCycles = 16,
   parameter logic [31:0] TimeoutCycles    = 32'd1_048_576
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  bootmode_i,
   input  logic        fetch_en_reg_i,
   input  logic [31:0] entry_addr_i,
   input  logic        entry_valid_i,
   output logic        core_rst_o,
   output logic        fetch_en_o,
   output logic [31:0] boot_addr_o,
   output logic        boot_done_o,
   output logic        boot_err_o,
   output logic        timeout_o,
   output logic [2:0]  state_o
);

   localparam logic [31:0] FallbackAddr = BaseAddr + BootRomOffset;
   localparam logic [BootDelayWidth-1:0] DelayLoad =
      BootDelayWidth'(ResetDelayCycles - 32'd1);

   boot_state_e state_q, state_d;
   logic [31:0] boot_addr_q, boot_addr_d;
   logic        core_rst_q, core_rst_d;
   logic        fetch_en_q, fetch_en_d;
   logic        boot_done_q, boot_done_d;
   logic        boot_err_q, boot_err_d;
   logic        timeout_q, timeout_d;

   logic                      dly_load, dly_dec, dly_zero;
   logic [BootDelayWidth-1:0] dly_cnt;

   // Core-reset hold counter.
   safety_island_boot_cnt #(
      .Width (BootDelayWidth)
   ) u_delay_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (dly_load),
      .load_val_i (DelayLoad),
      .dec_i      (dly_dec),
      .cnt_o      (dly_cnt),
      .zero_c     (dly_zero)
   );

`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
   logic                        to_load, to_dec, to_zero;
   logic [BootTimeoutWidth-1:0] to_cnt;

   // Preload timeout: loaded with TimeoutCycles-1 on entry to WaitPreload,
   // so reaching zero equals an up-count of TimeoutCycles-1.
   safety_island_boot_cnt #(
      .Width (BootTimeoutWidth)
   ) u_timeout_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (to_load),
      .load_val_i (BootTimeoutWidth'(TimeoutCycles - 32'd1)),
      .dec_i      (to_dec),
      .cnt_o      (to_cnt),
      .zero_c     (to_zero)
   );

   logic unused_to_cnt;
   assign unused_to_cnt = ^to_cnt;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
`endif

   logic unused_dly_cnt;
   assign unused_dly_cnt = ^dly_cnt;

   // Next state, counter control and next registered outputs.
   always_comb begin
      state_d     = state_q;
      boot_addr_d = boot_addr_q;
      timeout_d   = timeout_q;
      dly_load    = 1'b0;
      dly_dec     = 1'b0;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
      to_load     = 1'b0;
      to_dec      = 1'b0;
`endif

      unique case (state_q)
         Sample: begin
            case (bootmode_e'(bootmode_i))
               Jtag:      state_d = WaitJtag;
               Preloaded: begin
                  state_d = WaitPreload;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
                  to_load = 1'b1;
`endif
               end
               default:   state_d = Error;
            endcase
         end

         WaitJtag: begin
            if (fetch_en_reg_i) begin
               if (entry_addr_i[1:0] != 2'b00) begin
                  state_d = Error;
               end else begin
                  state_d     = Delay;
                  boot_addr_d = entry_addr_i;
                  dly_load    = 1'b1;
               end
            end
         end

         WaitPreload: begin
            // A valid entry in the expiry cycle takes priority over the fallback.
            if (entry_valid_i) begin
               if (entry_addr_i[1:0] != 2'b00) begin
                  state_d = Error;
               end else begin
                  state_d     = Delay;
                  boot_addr_d = entry_addr_i;
                  dly_load    = 1'b1;
               end
            end
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
            else if (to_zero) begin
               state_d     = Delay;
               boot_addr_d = FallbackAddr;
               timeout_d   = 1'b1;
               dly_load    = 1'b1;
            end else begin
               to_dec = 1'b1;
            end
`endif
         end

         Delay: begin
            if (dly_zero) begin
               state_d = Run;
            end else begin
               dly_dec = 1'b1;
            end
         end

         Run:     state_d = Run;
         Error:   state_d = Error;
         default: state_d = Error;
      endcase

      // Outputs are decoded from the next state so they change with it.
      core_rst_d  = (state_d != Run);
      fetch_en_d  = (state_d == Run);
      boot_done_d = (state_d == Run);
      boot_err_d  = (state_d == Error);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= Sample;
         boot_addr_q <= FallbackAddr;
         core_rst_q  <= 1'b1;
         fetch_en_q  <= 1'b0;
         boot_done_q <= 1'b0;
         boot_err_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_addr_q <= boot_addr_d;
         core_rst_q  <= core_rst_d;
         fetch_en_q  <= fetch_en_d;
         boot_done_q <= boot_done_d;
         boot_err_q  <= boot_err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign core_rst_o  = core_rst_q;
   assign fetch_en_o  = fetch_en_q;
   assign boot_addr_o = boot_addr_q;
   assign boot_done_o = boot_done_q;
   assign boot_err_o  = boot_err_q;
`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
   assign timeout_o   = timeout_q;
`else
   assign timeout_o   = 1'b0;
`endif
   assign state_o     = state_q;

endmodule : safety_island_boot_ctrl

// File: tb/tb_safety_island_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_safety_island_boot_ctrl
// Self-checking bench for the safety island boot sequencer. Each boot scenario
// is described by its mode, trigger cycle and entry address; expected outputs
// per cycle are derived from the boot timeline arithmetic.
// -----------------------------------------------------------------------------
module tb_safety_island_boot_ctrl;

   localparam int          R        = 4;
   localparam int          T        = 100;
   localparam logic [31:0] FALLBACK = 32'h6000_1000;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [1:0]  bootmode_i;
   logic        fetch_en_reg_i;
   logic [31:0] entry_addr_i;
   logic        entry_valid_i;
   logic        core_rst_o;
   logic        fetch_en_o;
   logic [31:0] boot_addr_o;
   logic        boot_done_o;
   logic        boot_err_o;
   logic        timeout_o;
   logic [2:0]  state_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   safety_island_boot_ctrl #(
      .BaseAddr         (32'h6000_0000),
      .BootRomOffset    (32'h0000_1000),
      .ResetDelayCycles (R),
      .TimeoutCycles    (T)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .bootmode_i     (bootmode_i),
      .fetch_en_reg_i (fetch_en_reg_i),
      .entry_addr_i   (entry_addr_i),
      .entry_valid_i  (entry_valid_i),
      .core_rst_o     (core_rst_o),
      .fetch_en_o     (fetch_en_o),
      .boot_addr_o    (boot_addr_o),
      .boot_done_o    (boot_done_o),
      .boot_err_o     (boot_err_o),
      .timeout_o      (timeout_o),
      .state_o        (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected state at cycle c of a boot (cycle 0 = first cycle out of reset).
   function automatic int exp_state(input int mode, input int n, input bit aligned, input int c);
      if (c == 0)        return 0;
      if (mode >= 2)     return 5;
      if (c <= n)        return (mode == 0) ? 1 : 2;
      if (!aligned)      return 5;
      if (c <= n + R)    return 3;
      return 4;
   endfunction

   // One boot: mode, trigger cycle n, entry address. fallback = no trigger at
   // all (timeout path). abort_at >= 0 pulses rst_i in that cycle and returns.
   task automatic run_boot(input string name, input int mode, input int n,
                           input logic [31:0] addr, input bit fallback,
                           input bit do_reset, input int abort_at);
      bit          aligned;
      int          st;
      int          last;
      logic [7:0]  estat, ostat;
      logic [31:0] eaddr;
      aligned        = (addr[1:0] == 2'b00);
      bootmode_i     = 2'(mode);
      fetch_en_reg_i = 1'b0;
      entry_valid_i  = 1'b0;
      if (do_reset) begin
         rst_i = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         rst_i = 1'b0;
      end
      last = n + R + 3;
      for (int c = 0; c <= last; c++) begin
         entry_addr_i   = $urandom();
         fetch_en_reg_i = 1'($urandom_range(0, 1));
         entry_valid_i  = 1'($urandom_range(0, 1));
         if (mode < 2 && c <= n) begin
            if (mode == 0) fetch_en_reg_i = (c == n);
            else           entry_valid_i  = (c == n) && !fallback;
            if (c == n)    entry_addr_i   = addr;
         end
         if (c == abort_at) rst_i = 1'b1;
         @(negedge clk);
         st    = exp_state(mode, n, aligned, c);
         estat = {3'(st), st != 4, st == 4, st == 4, st == 5,
                  fallback && (c > n) && (mode < 2)};
         ostat = {state_o, core_rst_o, fetch_en_o, boot_done_o, boot_err_o, timeout_o};
         eaddr = (mode < 2 && aligned && c > n) ? (fallback ? FALLBACK : addr) : FALLBACK;
         check($sformatf("%s c%0d status", name, c), {24'b0, ostat}, {24'b0, estat});
         check($sformatf("%s c%0d boot_addr", name, c), boot_addr_o, eaddr);
         @(posedge clk);
         #1;
         if (c == abort_at) begin
            rst_i = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      int          mode, n;
      logic [31:0] addr;
      rst_i          = 1'b1;
      bootmode_i     = 2'b00;
      fetch_en_reg_i = 1'b0;
      entry_addr_i   = '0;
      entry_valid_i  = 1'b0;

      // Directed boots.
      run_boot("jtag_1080",      0, 10, 32'h6000_1080, 1'b0, 1'b1, -1);
      run_boot("preload_10000",  1, 5,  32'h6001_0000, 1'b0, 1'b1, -1);
      run_boot("mode3_err",      3, 4,  32'h6000_2000, 1'b0, 1'b1, -1);
      run_boot("mode2_err",      2, 2,  32'h6000_2000, 1'b0, 1'b1, -1);
      run_boot("preload_misal",  1, 3,  32'h6000_1082, 1'b0, 1'b1, -1);
      run_boot("jtag_misal",     0, 2,  32'h6000_1081, 1'b0, 1'b1, -1);
      run_boot("jtag_min_lat",   0, 1,  32'h6000_4000, 1'b0, 1'b1, -1);
      run_boot("preload_min",    1, 1,  32'h6000_4004, 1'b0, 1'b1, -1);

      // Reset in the second Delay cycle, then a fresh boot.
      run_boot("abort",          0, 3,  32'h6000_2000, 1'b0, 1'b1, 3 + 2);
      run_boot("after_abort",    1, 2,  32'h6000_3004, 1'b0, 1'b0, -1);

      // Randomized boots.
      for (int i = 0; i < 12; i++) begin
         mode = int'($urandom_range(0, 3));
         n    = int'($urandom_range(1, 20));
         addr = $urandom();
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         run_boot($sformatf("rnd%0d", i), mode, n, addr, 1'b0, 1'b1, -1);
      end

`ifdef SAFETY_ISLAND_BOOT_TIMEOUT_EN
      run_boot("tmo_fallback",   1, T,  32'h6002_0040, 1'b1, 1'b1, -1);
      run_boot("tmo_race",       1, T,  32'h6003_0100, 1'b0, 1'b1, -1);
`else
      run_boot("preload_long",   1, 150, 32'h6003_0100, 1'b0, 1'b1, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_safety_island_boot_ctrl
